mul_div_unit: RTL and testbench

- Iterative 16-bit multiply/divide unit for the execute stage of the 16-bit MIPS-style core.
- Computes MULT/MULTU/DIV/DIVU into internal HI/LO registers.
- hi_out/lo_out feed the 16-bit writeback select mux, which chooses between the ALU result and HI/LO for MFHI/MFLO.
- The pipeline uses busy to stall while an operation is in flight.

---
 rtl/mul_div_unit.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative multiply/divide unit for the execute stage of the
//                16-bit MIPS-style core. It computes MULT/MULTU/DIV/DIVU into
//                internal HI/LO registers. One radix-2 step is done per clock.
//                Multiply uses shift-add. Divide uses restoring shift-subtract.
//                Signed operations run on magnitudes, and the signs are fixed
//                up in a final cycle.
//
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                start      - request pulse, sampled only while idle
//                op         - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//                op_a, op_b - multiplicand/dividend, multiplier/divisor
//                flush      - abort an in-flight operation
//                hi_we/lo_we/wdata - MTHI/MTLO write port (idle only)
//                busy       - operation in flight, pipeline must stall
//                done       - one-cycle pulse when HI/LO are updated
//                div_zero   - last completed divide had a zero divisor
//                hi_out/lo_out - HI and LO registers
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned c_CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_busy;

    // ------------------------------------------------------------------
    // Operation context captured at the accepting edge.
    // ------------------------------------------------------------------
    logic               r_op_div;   // 1: divide, 0: multiply
    logic               r_q_neg;    // product / quotient must be negated
    logic               r_r_neg;    // remainder must be negated (dividend sign)
    logic               r_b_zero;   // divisor was zero
    logic [WIDTH-1:0]   r_a_raw;    // untouched dividend, returned on /0
    logic [WIDTH-1:0]   r_opnd;     // |multiplicand| or |divisor|
    logic [WIDTH-1:0]   r_acc_hi;   // partial product high / partial remainder
    logic [WIDTH-1:0]   r_acc_lo;   // multiplier bits / dividend-quotient bits
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div_zero;

    // ------------------------------------------------------------------
    // Operand preparation. The signed ops are the even opcodes.
    // ------------------------------------------------------------------
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_accept;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & op_a[WIDTH-1];
    assign w_b_neg  = w_signed & op_b[WIDTH-1];
    // The most negative value maps to itself. Read as unsigned, that is the
    // correct magnitude.
    assign w_abs_a  = w_a_neg ? (~op_a + 1'b1) : op_a;
    assign w_abs_b  = w_b_neg ? (~op_b + 1'b1) : op_b;

    // Flush beats start in the idle cycle.
    assign w_accept = (r_state == S_IDLE) && start && !flush;

    // ------------------------------------------------------------------
    // Iteration datapath.
    // ------------------------------------------------------------------
    // Multiply step: conditionally add the multiplicand into the high half,
    // then shift the whole {carry, hi, lo} right by one.
    logic [WIDTH:0] w_add;
    assign w_add = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);

    // Divide step: shift the next dividend bit into the partial remainder and
    // try to subtract the divisor. The partial remainder is always below the
    // divisor, so the shifted value fits in WIDTH+1 bits. When the subtraction
    // succeeds, the difference fits in WIDTH bits, so modular low bits are
    // enough.
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opnd});
    assign w_sub   = w_shift[WIDTH-1:0] - r_opnd;

    // ------------------------------------------------------------------
    // Sign fix-up of the raw magnitude results.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_q_neg ? (~w_prod + 1'b1) : w_prod;
    // The signed 0x8000 / -1 case wraps to 0x8000 by construction.
    assign w_quo_fix  = r_q_neg ? (~r_acc_lo + 1'b1) : r_acc_lo;
    assign w_rem_fix  = r_r_neg ? (~r_acc_hi + 1'b1) : r_acc_hi;

    // ------------------------------------------------------------------
    // FSM: state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and busy.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (flush) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == c_LAST) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                w_busy       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and architectural registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_div   <= 1'b0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_b_zero   <= 1'b0;
            r_a_raw    <= '0;
            r_opnd     <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_div <= op[1];
                        r_q_neg  <= w_a_neg ^ w_b_neg;
                        r_r_neg  <= w_a_neg;
                        r_b_zero <= (op_b == '0);
                        r_a_raw  <= op_a;
                        r_cnt    <= '0;
                        r_acc_hi <= '0;
                        // A multiply walks through the multiplier bits.
                        // A divide walks through the dividend bits.
                        r_opnd   <= op[1] ? w_abs_b : w_abs_a;
                        r_acc_lo <= op[1] ? w_abs_a : w_abs_b;
                    end else if (!start) begin
                        // An MTHI/MTLO that comes with start is dropped.
                        if (hi_we) begin
                            r_hi <= wdata;
                        end
                        if (lo_we) begin
                            r_lo <= wdata;
                        end
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_op_div) begin
                            r_acc_hi <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
                        end else begin
                            r_acc_hi <= w_add[WIDTH:1];
                            r_acc_lo <= {w_add[0], r_acc_lo[WIDTH-1:1]};
                        end
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (r_op_div && r_b_zero) begin
                            r_lo       <= '1;
                            r_hi       <= r_a_raw;
                            r_div_zero <= 1'b1;
                        end else if (r_op_div) begin
                            r_lo       <= w_quo_fix;
                            r_hi       <= w_rem_fix;
                            r_div_zero <= 1'b0;
                        end else begin
                            r_lo       <= w_prod_fix[WIDTH-1:0];
                            r_hi       <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_div_zero <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign busy     = w_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi_out   = r_hi;
    assign lo_out   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Directed self-checking bench for mul_div_unit. Inputs change
//                and outputs are sampled on the falling edge. Expected
//                values are hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [15:0] hi_out;
    logic [15:0] lo_out;

    int n_cmp;
    int n_bad;

    localparam logic [1:0] c_MULT  = 2'b00;
    localparam logic [1:0] c_MULTU = 2'b01;
    localparam logic [1:0] c_DIV   = 2'b10;
    localparam logic [1:0] c_DIVU  = 2'b11;

    mul_div_unit #(.WIDTH(16), .ITER(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .op_a     (op_a),
        .op_b     (op_b),
        .flush    (flush),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string nm, input logic [15:0] hi, input logic [15:0] lo,
                                input logic dz);
        check({nm, ".hi"}, 32'(hi_out), 32'(hi));
        check({nm, ".lo"}, 32'(lo_out), 32'(lo));
        check({nm, ".div_zero"}, 32'(div_zero), 32'(dz));
    endtask

    // The task is called at a falling edge. It returns at the falling edge
    // where done is seen, or when the cycle budget runs out. With poke set,
    // it raises start again 5 cycles after the accepting edge.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input bit poke);
        int n;
        bit busy_ok;
        op    = o;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a  = ~a;             // operand isolation: scramble after capture
        op_b  = b ^ 16'h5A5A;
        n       = 1;
        busy_ok = 1'b1;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (poke && n == 5) begin
                start = 1'b1;
                op    = c_MULTU;
                op_a  = 16'h0007;
                op_b  = 16'h0007;
            end
            if (poke && n == 6) start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({nm, ".done"}, 32'(done), 32'd1);
        check({nm, ".latency"}, 32'(n), 32'd18);
        check({nm, ".busy_during"}, 32'(busy_ok), 32'd1);
        check({nm, ".busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit seen_done;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        op_a  = '0;
        op_b  = '0;
        flush = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check_result("reset", 16'h0000, 16'h0000, 1'b0);

        // 1: MULTU max x max, latency and a one-cycle done
        run_op("multu_ffff", c_MULTU, 16'hFFFF, 16'hFFFF, 1'b0);
        check_result("multu_ffff", 16'hFFFE, 16'h0001, 1'b0);
        @(negedge clk);
        check("multu_ffff.done_one_cycle", 32'(done), 32'd0);

        // 2: signed multiply
        run_op("mult_neg", c_MULT, 16'hFFFD, 16'h0007, 1'b0);
        check_result("mult_neg", 16'hFFFF, 16'hFFEB, 1'b0);
        @(negedge clk);
        run_op("mult_min", c_MULT, 16'h8000, 16'h8000, 1'b0);
        check_result("mult_min", 16'h4000, 16'h0000, 1'b0);
        @(negedge clk);

        // 3: divides
        run_op("div_neg", c_DIV, 16'hFFF9, 16'h0002, 1'b0);
        check_result("div_neg", 16'hFFFF, 16'hFFFD, 1'b0);
        @(negedge clk);
        run_op("divu_100_7", c_DIVU, 16'd100, 16'd7, 1'b0);
        check_result("divu_100_7", 16'h0002, 16'h000E, 1'b0);
        @(negedge clk);
        run_op("div_ovf", c_DIV, 16'h8000, 16'hFFFF, 1'b0);
        check_result("div_ovf", 16'h0000, 16'h8000, 1'b0);
        @(negedge clk);

        // 4: divide by zero, then clear by a normal op (with an ignored start)
        run_op("divu_zero", c_DIVU, 16'h1234, 16'h0000, 1'b0);
        check_result("divu_zero", 16'h1234, 16'hFFFF, 1'b1);
        @(negedge clk);
        run_op("multu_2x3", c_MULTU, 16'h0002, 16'h0003, 1'b1);
        check_result("multu_2x3", 16'h0000, 16'h0006, 1'b0);
        @(negedge clk);

        // 5a: flush mid-operation keeps HI/LO and div_zero
        run_op("div_zero2", c_DIV, 16'h0042, 16'h0000, 1'b0);
        check_result("div_zero2", 16'h0042, 16'hFFFF, 1'b1);
        @(negedge clk);
        op    = c_MULTU;
        op_a  = 16'h0005;
        op_b  = 16'h0005;
        start = 1'b1;
        @(negedge clk);                 // cycle 1
        start = 1'b0;
        repeat (4) @(negedge clk);      // cycle 5
        start = 1'b1;
        op_a  = 16'h0009;
        @(negedge clk);                 // cycle 6
        start = 1'b0;
        repeat (2) @(negedge clk);      // cycle 8
        flush = 1'b1;
        @(negedge clk);                 // cycle 9
        flush = 1'b0;
        check("flush.busy", 32'(busy), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        check("flush.no_done", 32'(seen_done), 32'd0);
        check("flush.busy_idle", 32'(busy), 32'd0);
        check_result("flush", 16'h0042, 16'hFFFF, 1'b1);

        // 5b: reset mid-operation
        op    = c_MULTU;
        op_a  = 16'h0005;
        op_b  = 16'h0005;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);      // cycle 8
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check_result("midrst", 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);

        // 6: MTLO / MTHI in idle
        lo_we = 1'b1;
        wdata = 16'hBEEF;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo.lo", 32'(lo_out), 32'h0000BEEF);
        check("mtlo.hi", 32'(hi_out), 32'h00000000);
        hi_we = 1'b1;
        wdata = 16'h1111;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi.hi", 32'(hi_out), 32'h00001111);

        // start beats lo_we: the write is dropped and the result lands
        op    = c_MULTU;
        op_a  = 16'h0002;
        op_b  = 16'h0002;
        lo_we = 1'b1;
        wdata = 16'hDEAD;
        start = 1'b1;
        @(negedge clk);
        lo_we = 1'b0;
        start = 1'b0;
        check("mtlo_drop.lo", 32'(lo_out), 32'h0000BEEF);
        repeat (30) @(negedge clk);
        check_result("mtlo_drop", 16'h0000, 16'h0004, 1'b0);

        // Back-to-back: the second start is issued in the done cycle
        run_op("b2b_first", c_DIVU, 16'd100, 16'd7, 1'b0);
        check_result("b2b_first", 16'h0002, 16'h000E, 1'b0);
        run_op("b2b_second", c_MULTU, 16'hFFFF, 16'h0002, 1'b0);
        check_result("b2b_second", 16'h0001, 16'hFFFE, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
